// File: rtl/fp_add_sequencer.sv
// ============================================================================
// fp_add_sequencer : iterative IEEE-754 binary32 adder (compare/align/add/norm)
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_add_sequencer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic                     out_overflow
);

  localparam int WIDTH = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int SUM_W = MAN_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMP   = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [EXP_W-1:0] C_EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] C_EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] C_ALIGN_MAX = EXP_W'(MAN_W + 2);
  localparam logic [WIDTH-1:0] C_QNAN      = {1'b0, C_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sign_q, sign_d, sub_q, sub_d;
  logic [EXP_W-1:0] exp_q, exp_d, shift_cnt_q, shift_cnt_d;
  logic [SIG_W-1:0] big_sig_q, big_sig_d, small_sig_q, small_sig_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  // Operand decode, consumed in CMP
  logic             w_a_ge_b;
  logic [WIDTH-1:0] w_big, w_small;
  logic [EXP_W-1:0] w_big_exp, w_small_exp, w_a_exp, w_b_exp;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special;
  logic [WIDTH-1:0] w_special_res;

  assign w_a_ge_b    = a_q[WIDTH-2:0] >= b_q[WIDTH-2:0];
  assign w_big       = w_a_ge_b ? a_q : b_q;
  assign w_small     = w_a_ge_b ? b_q : a_q;
  assign w_big_exp   = w_big[WIDTH-2:MAN_W];
  assign w_small_exp = w_small[WIDTH-2:MAN_W];
  assign w_a_exp     = a_q[WIDTH-2:MAN_W];
  assign w_b_exp     = b_q[WIDTH-2:MAN_W];
  assign w_a_nan     = (w_a_exp == C_EXP_ONES) && (a_q[MAN_W-1:0] != '0);
  assign w_b_nan     = (w_b_exp == C_EXP_ONES) && (b_q[MAN_W-1:0] != '0);
  assign w_a_inf     = (w_a_exp == C_EXP_ONES) && (a_q[MAN_W-1:0] == '0);
  assign w_b_inf     = (w_b_exp == C_EXP_ONES) && (b_q[MAN_W-1:0] == '0);
  assign w_special   = (w_a_exp == C_EXP_ONES) || (w_b_exp == C_EXP_ONES);

  always_comb begin
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a_q[WIDTH-1] != b_q[WIDTH-1])))
      w_special_res = C_QNAN;
    else if (w_a_inf)
      w_special_res = {a_q[WIDTH-1], C_EXP_ONES, {MAN_W{1'b0}}};
    else
      w_special_res = {b_q[WIDTH-1], C_EXP_ONES, {MAN_W{1'b0}}};
  end

  // Normalisation decode, consumed in NORM
  logic             w_sum_zero, w_sum_carry, w_sum_norm, w_exp_gt1;
  logic [EXP_W-1:0] w_exp_inc;

  assign w_sum_zero  = (sum_q == '0);
  assign w_sum_carry = sum_q[SUM_W-1];
  assign w_sum_norm  = sum_q[MAN_W];
  assign w_exp_gt1   = exp_q > C_EXP_ONE;
  assign w_exp_inc   = exp_q + C_EXP_ONE;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CMP;
      S_CMP: begin
        if (w_special)                    state_d = S_DONE;
        else if (w_big_exp != w_small_exp) state_d = S_ALIGN;
        else                              state_d = S_ADD;
      end
      S_ALIGN: if (shift_cnt_q >= C_ALIGN_MAX || shift_cnt_q == C_EXP_ONE) state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  if (w_sum_zero || w_sum_carry || w_sum_norm || !w_exp_gt1) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE);
    out_valid    = (state_q == S_DONE);
    out_result   = result_q;
    out_overflow = ovf_q;
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    exp_d       = exp_q;
    shift_cnt_d = shift_cnt_q;
    big_sig_d   = big_sig_q;
    small_sig_d = small_sig_q;
    sum_d       = sum_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
        end
      end
      S_CMP: begin
        sign_d      = w_big[WIDTH-1];
        sub_d       = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        exp_d       = w_big_exp;
        shift_cnt_d = w_big_exp - w_small_exp;
        big_sig_d   = (w_big_exp == '0)   ? '0 : {1'b1, w_big[MAN_W-1:0]};
        small_sig_d = (w_small_exp == '0) ? '0 : {1'b1, w_small[MAN_W-1:0]};
        if (w_special) begin
          result_d = w_special_res;
          ovf_d    = 1'b0;
        end
      end
      S_ALIGN: begin
        if (shift_cnt_q >= C_ALIGN_MAX) begin
          small_sig_d = '0;
          shift_cnt_d = '0;
        end else begin
          small_sig_d = small_sig_q >> 1;
          shift_cnt_d = shift_cnt_q - C_EXP_ONE;
        end
      end
      S_ADD: begin
        // Big has the larger magnitude, so the difference never goes negative
        sum_d = sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                      : ({1'b0, big_sig_q} + {1'b0, small_sig_q});
      end
      S_NORM: begin
        if (w_sum_zero) begin
          result_d = '0;
          ovf_d    = 1'b0;
        end else if (w_sum_carry) begin
          if (w_exp_inc == C_EXP_ONES) begin
            result_d = {sign_q, C_EXP_ONES, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, w_exp_inc, sum_q[MAN_W:1]};
            ovf_d    = 1'b0;
          end
        end else if (w_sum_norm) begin
          result_d = {sign_q, exp_q, sum_q[MAN_W-1:0]};
          ovf_d    = 1'b0;
        end else if (w_exp_gt1) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - C_EXP_ONE;
        end else begin
          result_d = {sign_q, {(WIDTH-1){1'b0}}};
          ovf_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      exp_q       <= '0;
      shift_cnt_q <= '0;
      big_sig_q   <= '0;
      small_sig_q <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      exp_q       <= exp_d;
      shift_cnt_q <= shift_cnt_d;
      big_sig_q   <= big_sig_d;
      small_sig_q <= small_sig_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_add_sequencer.sv
// ============================================================================
// tb_fp_add_sequencer : directed self-checking bench for fp_add_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready, out_valid, out_overflow;
  logic [31:0] out_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_add_sequencer #(.EXP_W(8), .MAN_W(23)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow)
  );

  // Starts from IDLE; returns at the first negedge where out_valid is high.
  // lat is the index of the clock edge (handshake = edge 0) that first sees out_valid.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ovf,
                       output int lat, output int rdy_seen);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    res = out_result;
    ovf = out_overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result got=%h exp=00000000", out_result); end
    n_tests++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", out_overflow); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_one_plus_one();
    logic [31:0] r; logic o; int lat, rs;
    out_ready = 1'b1;
    do_op(32'h3F800000, 32'h3F800000, r, o, lat, rs);
    n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL add_1p1_result got=%h exp=40000000", r); end
    n_tests++; if (o !== 1'b0) begin n_fail++; $display("FAIL add_1p1_ovf got=%b exp=0", o); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL add_1p1_latency got=%0d exp=4", lat); end
    n_tests++; if (rs != 0) begin n_fail++; $display("FAIL add_1p1_in_ready_busy got=%0d exp=0", rs); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_1p1_consumed_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_1p1_consumed_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_align();
    logic [31:0] r; logic o; int lat, rs;
    do_op(32'h40400000, 32'h3F000000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h40600000) begin n_fail++; $display("FAIL align_result got=%h exp=40600000", r); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL align_latency got=%0d exp=6", lat); end
    do_op(32'h3F000000, 32'h40400000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h40600000) begin n_fail++; $display("FAIL align_swap_result got=%h exp=40600000", r); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL align_swap_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_cancel_and_far();
    logic [31:0] r; logic o; int lat, rs;
    do_op(32'h3F800000, 32'hBF800000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL cancel_result got=%h exp=00000000", r); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL cancel_latency got=%0d exp=4", lat); end
    do_op(32'h3F800000, 32'h30800000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL far_shift_result got=%h exp=3F800000", r); end
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL far_shift_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_norm_left();
    logic [31:0] r; logic o; int lat, rs;
    do_op(32'h3FC00000, 32'hBF800000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h3F000000) begin n_fail++; $display("FAIL norm_left_result got=%h exp=3F000000", r); end
    n_tests++; if (o !== 1'b0) begin n_fail++; $display("FAIL norm_left_ovf got=%b exp=0", o); end
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL norm_left_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_special();
    logic [31:0] r; logic o; int lat, rs;
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL overflow_result got=%h exp=7F800000", r); end
    n_tests++; if (o !== 1'b1) begin n_fail++; $display("FAIL overflow_flag got=%b exp=1", o); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL overflow_latency got=%0d exp=4", lat); end
    do_op(32'h7F800000, 32'hFF800000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL inf_minus_inf_result got=%h exp=7FC00000", r); end
    n_tests++; if (o !== 1'b0) begin n_fail++; $display("FAIL inf_minus_inf_ovf got=%b exp=0", o); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL inf_minus_inf_latency got=%0d exp=2", lat); end
    do_op(32'h7FC00001, 32'h3F800000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL nan_in_result got=%h exp=7FC00000", r); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL nan_in_latency got=%0d exp=2", lat); end
    do_op(32'h3F800000, 32'hFF800000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'hFF800000) begin n_fail++; $display("FAIL neg_inf_result got=%h exp=FF800000", r); end
    n_tests++; if (o !== 1'b0) begin n_fail++; $display("FAIL neg_inf_ovf got=%b exp=0", o); end
  endtask

  task automatic test_hold();
    logic [31:0] r; logic o; int lat, rs;
    out_ready = 1'b0;
    do_op(32'h3F800000, 32'h3F800000, r, o, lat, rs);
    n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL hold_first_result got=%h exp=40000000", r); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = 32'h40800000 + 32'(i) * 32'h00100000;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, out_valid); end
      n_tests++; if (out_result !== 32'h40000000) begin n_fail++; $display("FAIL hold_result[%0d] got=%h exp=40000000", i, out_result); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_no_accept got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_align();
    logic [31:0] r; logic o; int lat, rs;
    int seen;
    @(negedge clk);
    in_a = 32'h3F800000;
    in_b = 32'h3B800000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_align_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_align_ready got=%b exp=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_align_no_result got=%0d exp=0", seen); end
    do_op(32'h3F800000, 32'h3F800000, r, o, lat, rs);
    @(negedge clk);
    n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL rst_align_after_result got=%h exp=40000000", r); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL rst_align_after_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    test_reset();
    test_one_plus_one();
    test_align();
    test_cancel_and_far();
    test_norm_left();
    test_special();
    test_hold();
    test_reset_align();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Multi-cycle controller and datapath sequencer for IEEE-754 binary32 addition.
- Accepts an operand pair over a valid/ready handshake, then steps one state per cycle: magnitude compare/swap, bit-serial alignment, add/subtract, bit-serial normalisation.
- Returns the result over a valid/ready handshake.
- Sits between the operand source and the result consumer as the iterative, low-area FP add unit.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width.
- width, 1+EXP_W+MAN_W (32), total word width.
- The magnitude compare uses the low width-1 bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in_a  input  width  operand A.
- in_b  input  width  operand B.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts result.
- out_result  output  width  sum, registered.
- out_overflow  output  1  finite operands overflowed to infinity; registered, qualified by out_valid.

Behaviour:
- Reset: state IDLE, out_valid=0, out_result=0, out_overflow=0, all internal registers 0. in_ready=1 in the cycle after reset. rst asserted in any state, including mid-ALIGN, NORM or DONE, aborts the operation; no result is produced.
- in_ready = (state==IDLE). Handshake fires when in_valid & in_ready. Operands are registered and the state moves to CMP. in_valid is ignored outside IDLE.
- CMP (1 cycle):
  - big = A if A[width-2:0] >= B[width-2:0], else B. Equal magnitudes select A.
  - Sign of result = sign of big. shift_cnt = exp_big - exp_small.
  - Significand = {1,mant}; exponent 0 means zero/denormal, flushed to zero significand.
  - Special case: if either exponent is all-ones, go directly to DONE with:
    - 0x7FC00000 when any operand is NaN, or for inf + (-inf);
    - otherwise infinity with the sign of the infinite operand.
    - out_overflow=0 in all special cases.
  - Otherwise go to ALIGN if shift_cnt != 0, else ADD.
- ALIGN:
  - If shift_cnt >= MAN_W+2 (25): small significand := 0, go to ADD (1 cycle).
  - Otherwise shift the small significand right 1 bit per cycle, decrementing shift_cnt. Go to ADD in the cycle shift_cnt reaches 0.
  - Shifted-out bits are discarded (truncation).
- ADD (1 cycle):
  - Same signs: sum = big + small, MAN_W+2 bits.
  - Different signs: sum = big - small (never negative).
  - Exponent register = exp_big.
- NORM, evaluated each cycle:
  - sum==0: result = +0 (0x00000000), go to DONE.
  - sum[MAN_W+1]=1: shift right 1, exp+1, go to DONE.
    - If the new exp is all-ones: result = signed infinity, out_overflow=1.
  - sum[MAN_W]=1: pack {sign, exp, sum[MAN_W-1:0]}, go to DONE.
  - Otherwise, if exp > 1: shift left 1, exp-1, stay in NORM.
  - Otherwise (underflow): result = signed zero, go to DONE.
- DONE:
  - out_valid=1. out_result and out_overflow are stable while out_valid & !out_ready.
  - On out_ready: out_valid drops the next cycle, state returns to IDLE, and in_ready=1 that cycle.
  - No acceptance occurs in the cycle the result is consumed.
- Rounding: round-toward-zero via truncation only. Denormal outputs are never produced.
- Latency: handshake at edge 0, then out_valid is high at cycle 4 + ALIGN cycles + (NORM cycles - 1). Special cases give out_valid at cycle 2.
- Throughput: one operation in flight; no pipelining.

Test Plan:
- 0x3F800000 + 0x3F800000 (1+1), out_ready=1 → out_result 0x40000000, overflow 0, out_valid high exactly 4 cycles after handshake, in_ready low meanwhile.
- 0x40400000 + 0x3F000000 (3+0.5) → 0x40600000 after 2 ALIGN cycles (out_valid at cycle 6). Swapped operand order gives the same result and latency.
- 0x3F800000 + 0xBF800000 (1 + -1) → 0x00000000. 0x3F800000 + 0x30800000 (shift 30 ≥ 25, 1 ALIGN cycle) → 0x3F800000.
- 0x3FC00000 + 0xBF800000 (1.5 - 1) → 0x3F000000 with 1 extra NORM left-shift cycle.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow 1. 0x7F800000 + 0xFF800000 → 0x7FC00000 at cycle 2. 0x7FC00001 + any → 0x7FC00000.
- Hold out_ready=0 for 5 cycles with in_valid=1 and changing in_a: result stable, in_ready 0, no new accept. Assert rst during ALIGN → next cycle IDLE, out_valid 0, in_ready 1, and a subsequent 1+1 completes correctly.
